pc_multich_packetizer: RTL and testbench

- Multi-channel successor to the single-channel count-to-pipe path.
- Captures simultaneous lock-in up/down count pairs from NCH photon-counter channels, which arrive already synchronised into g_clk.
- Serialises each capture into a framed 32-bit word stream with header, sequence number and drop accounting.
- Buffers frames in an internal circular buffer that feeds a block-throttled pipe-out endpoint.

---
 rtl/pc_multich_packetizer_if.sv | 31 +++
 rtl/pc_multich_packetizer.sv | 169 ++++++++++++++++
 tb/tb_pc_multich_packetizer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_multich_packetizer_if.sv
// Bus bundle for pc_multich_packetizer.
// Groups the capture side (enable, in_valid, in_data), the pipe read side
// (rd_en, dout, empty, ready, level) and the status outputs (drop_total,
// underflow). The master modport is the producer/host side; the slave
// modport is the packetizer itself.
interface pc_multich_packetizer_if #(
  parameter int NCH        = 4,
  parameter int COUNTSIZE  = 32,
  parameter int DEPTH_LOG2 = 10
);
  logic                       enable;
  logic                       in_valid;
  logic [NCH*2*COUNTSIZE-1:0] in_data;
  logic                       rd_en;
  logic [31:0]                dout;
  logic                       empty;
  logic                       ready;
  logic [DEPTH_LOG2:0]        level;
  logic [15:0]                drop_total;
  logic                       underflow;

  modport master (
    output enable, in_valid, in_data, rd_en,
    input  dout, empty, ready, level, drop_total, underflow
  );

  modport slave (
    input  enable, in_valid, in_data, rd_en,
    output dout, empty, ready, level, drop_total, underflow
  );
endinterface

// File: rtl/pc_multich_packetizer.sv
// Multi-channel photon-counter packetizer.
// Captures NCH up/down count pairs on a one-cycle in_valid strobe, frames
// them as a header word followed by the data words (ch0 up, ch0 down, ch1
// up, ...) and stores the frame in a circular buffer read by a pipe-out
// endpoint with first-word-fall-through semantics.
// Optional feature: define PC_PKT_CHECKSUM_EN to append a trailer word that
// is the XOR of the header and all data words of the frame.
// Ports:
//   g_clk  - clock, all logic in this domain
//   c_rst  - asynchronous active-high reset
//   bus    - slave side of pc_multich_packetizer_if (capture inputs, read
//            side, level/ready/empty, drop_total, sticky underflow)
module pc_multich_packetizer #(
  parameter int NCH         = 4,
  parameter int COUNTSIZE   = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int BLOCK_WORDS = 16
) (
  input  logic                   g_clk,
  input  logic                   c_rst,
  pc_multich_packetizer_if.slave bus
);
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int NWORDS = 2 * NCH;
`ifdef PC_PKT_CHECKSUM_EN
  localparam int FRAME_LEN = NWORDS + 2;
`else
  localparam int FRAME_LEN = NWORDS + 1;
`endif
  localparam int IDX_W = $clog2(NWORDS + 1);
  localparam int LW    = DEPTH_LOG2 + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  typedef enum logic [1:0] {IDLE, HDR, DATA, TRL} state_t;
  state_t state, state_nxt;

  logic [31:0]                mem [DEPTH];
  logic [DEPTH_LOG2-1:0]      wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [LW-1:0]              level, level_nxt;
  logic [NCH*2*COUNTSIZE-1:0] snap;
  logic [IDX_W-1:0]           idx;
  logic [7:0]                 seq;
  logic [6:0]                 pending;
  logic [15:0]                drop_total;
  logic [31:0]                dout;
  logic                       underflow;
  logic                       capture, space_ok, accept, drop, wr_en, pop;
  logic [31:0]                wr_data, hdr_word, data_word;
`ifdef PC_PKT_CHECKSUM_EN
  logic [31:0]                csum;
`endif

  function automatic logic [31:0] zext(input logic [COUNTSIZE-1:0] v);
    logic [31:0] w;
    w = '0;
    w[COUNTSIZE-1:0] = v;
    return w;
  endfunction

  assign capture   = bus.enable && bus.in_valid;
  // In IDLE nothing is being written, so the current level is exact.
  assign space_ok  = (level <= LW'(DEPTH - FRAME_LEN));
  assign hdr_word  = {8'hA5, seq, (pending != 7'd0), pending, 8'(NCH)};
  // Snapshot words are laid out contiguously in word order.
  assign data_word = zext(snap[int'(idx)*COUNTSIZE +: COUNTSIZE]);

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_data   = '0;
    accept    = 1'b0;
    drop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (capture) begin
          if (space_ok) begin
            accept    = 1'b1;
            state_nxt = HDR;
          end else begin
            drop = 1'b1;
          end
        end
      end
      HDR: begin
        drop      = capture;
        wr_en     = 1'b1;
        wr_data   = hdr_word;
        state_nxt = DATA;
      end
      DATA: begin
        drop    = capture;
        wr_en   = 1'b1;
        wr_data = data_word;
        if (idx == LAST_IDX) begin
`ifdef PC_PKT_CHECKSUM_EN
          state_nxt = TRL;
`else
          state_nxt = IDLE;
`endif
        end
      end
`ifdef PC_PKT_CHECKSUM_EN
      TRL: begin
        drop      = capture;
        wr_en     = 1'b1;
        wr_data   = csum;
        state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  assign pop        = bus.rd_en && (level != '0);
  assign rd_ptr_nxt = rd_ptr + DEPTH_LOG2'(pop);
  assign level_nxt  = level + LW'(wr_en) - LW'(pop);

  always_ff @(posedge g_clk or posedge c_rst) begin
    if (c_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Control and read-side registers
  always_ff @(posedge g_clk or posedge c_rst) begin
    if (c_rst) begin
      seq        <= '0;
      pending    <= '0;
      drop_total <= '0;
      idx        <= '0;
      underflow  <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      dout       <= '0;
    end else begin
      if (state == HDR) seq <= seq + 8'd1;
      // A drop during the header write belongs to the next frame.
      if (state == HDR)                       pending <= drop ? 7'd1 : 7'd0;
      else if (drop && pending != 7'h7F)      pending <= pending + 7'd1;
      if (drop && drop_total != 16'hFFFF)     drop_total <= drop_total + 16'd1;
      if (state == HDR)                       idx <= '0;
      else if (state == DATA)                 idx <= idx + IDX_W'(1);
      if (bus.rd_en && level == '0)           underflow <= 1'b1;
      if (wr_en)                              wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      rd_ptr <= rd_ptr_nxt;
      level  <= level_nxt;
      // Head word is registered; bypass the write when it lands on the new head.
      if (level_nxt != '0)
        dout <= (wr_en && wr_ptr == rd_ptr_nxt) ? wr_data : mem[rd_ptr_nxt];
    end
  end

  // Data storage
  always_ff @(posedge g_clk) begin
    if (accept) snap <= bus.in_data;
    if (wr_en)  mem[wr_ptr] <= wr_data;
`ifdef PC_PKT_CHECKSUM_EN
    if (state == HDR)       csum <= hdr_word;
    else if (state == DATA) csum <= csum ^ data_word;
`endif
  end

  assign bus.dout       = dout;
  assign bus.empty      = (level == '0);
  assign bus.ready      = (level >= LW'(BLOCK_WORDS));
  assign bus.level      = level;
  assign bus.drop_total = drop_total;
  assign bus.underflow  = underflow;
endmodule

// File: tb/tb_pc_multich_packetizer.sv
// Testbench for pc_multich_packetizer (default build, NCH=2, COUNTSIZE=32).
// Instance u_a uses a 1024-word buffer; u_b uses a 16-word buffer for the
// space-check scenario.
module tb_pc_multich_packetizer;
  logic g_clk;
  logic c_rst;
  int   total = 0;
  int   bad   = 0;

  pc_multich_packetizer_if #(.NCH(2), .COUNTSIZE(32), .DEPTH_LOG2(10)) ifa ();
  pc_multich_packetizer_if #(.NCH(2), .COUNTSIZE(32), .DEPTH_LOG2(4))  ifb ();

  pc_multich_packetizer #(.NCH(2), .COUNTSIZE(32), .DEPTH_LOG2(10), .BLOCK_WORDS(16)) u_a (
    .g_clk(g_clk), .c_rst(c_rst), .bus(ifa)
  );
  pc_multich_packetizer #(.NCH(2), .COUNTSIZE(32), .DEPTH_LOG2(4), .BLOCK_WORDS(16)) u_b (
    .g_clk(g_clk), .c_rst(c_rst), .bus(ifb)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, required completion before it");
    $fatal(1);
  end

  typedef struct packed {
    logic            en;
    logic [3:0][31:0] cnt;   // [0]=ch0 up, [1]=ch0 down, [2]=ch1 up, [3]=ch1 down
    logic [4:0][31:0] exp;   // [0]=header, [1..4]=data words
  } vec_t;

  vec_t tbl [5];

  function automatic vec_t mk(input logic en, input logic [31:0] u0, d0, u1, d1, h);
    vec_t v;
    v.en  = en;
    v.cnt = {d1, u1, d0, u0};
    v.exp = {d1, u1, d0, u0, h};
    return v;
  endfunction

  function automatic logic [127:0] pack4(input logic [31:0] u0, d0, u1, d1);
    return {d1, u1, d0, u0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic pulse_a(input logic [127:0] d);
    ifa.in_data  = d;
    ifa.in_valid = 1'b1;
    @(negedge g_clk);
    ifa.in_valid = 1'b0;
  endtask

  task automatic pulse_b(input logic [127:0] d);
    ifb.in_data  = d;
    ifb.in_valid = 1'b1;
    @(negedge g_clk);
    ifb.in_valid = 1'b0;
  endtask

  task automatic pop_a(output logic [31:0] w);
    int n;
    n = 0;
    while (ifa.empty && n < 200) begin
      @(negedge g_clk);
      n++;
    end
    if (ifa.empty) begin
      total++;
      bad++;
      $display("FAIL pop_timeout: empty=%b after %0d cycles, required a word", ifa.empty, n);
      w = 'x;
    end else begin
      w = ifa.dout;
      ifa.rd_en = 1'b1;
      @(negedge g_clk);
      ifa.rd_en = 1'b0;
    end
  endtask

  task automatic reset_dut();
    c_rst = 1'b1;
    repeat (2) @(negedge g_clk);
    c_rst = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    c_rst = 1'b1;
    ifa.enable = 1'b1; ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.rd_en = 1'b0;
    ifb.enable = 1'b1; ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.rd_en = 1'b0;

    tbl[0] = mk(1'b1, 32'd5, 32'd7, 32'd9, 32'd11, 32'hA5000002);
    tbl[1] = mk(1'b1, 32'h0, 32'hFFFFFFFF, 32'h12345678, 32'h1, 32'hA5010002);
    tbl[2] = mk(1'b1, 32'hDEADBEEF, 32'hCAFEF00D, 32'h80000000, 32'h7FFFFFFF, 32'hA5020002);
    tbl[3] = mk(1'b0, 32'h11, 32'h22, 32'h33, 32'h44, 32'h0);
    tbl[4] = mk(1'b1, 32'd1, 32'd2, 32'd3, 32'd4, 32'hA5030002);

    repeat (2) @(negedge g_clk);
    chk("rst_dout", ifa.dout, 0);
    chk("rst_empty", ifa.empty, 1);
    chk("rst_ready", ifa.ready, 0);
    chk("rst_level", ifa.level, 0);
    chk("rst_drop", ifa.drop_total, 0);
    chk("rst_underflow", ifa.underflow, 0);
    c_rst = 1'b0;
    @(negedge g_clk);

    // Small buffer: three frames fit (15 words), the fourth is dropped.
    for (int i = 0; i < 4; i++) begin
      pulse_b(pack4(32'(i), 32'(i + 1), 32'(i + 2), 32'(i + 3)));
      repeat (6) @(negedge g_clk);
      if (i == 2) chk("b_level_3frames", ifb.level, 15);
    end
    chk("b_level_final", ifb.level, 15);
    chk("b_drop_total", ifb.drop_total, 1);
    chk("b_ready", ifb.ready, 0);

    // Table-driven single frames with latency and level checks.
    for (int i = 0; i < 5; i++) begin
      ifa.enable = tbl[i].en;
      pulse_a(tbl[i].cnt);
      chk($sformatf("v%0d_empty_t1", i), ifa.empty, 1);
      if (tbl[i].en) begin
        @(negedge g_clk);
        chk($sformatf("v%0d_empty_t2", i), ifa.empty, 0);
        chk($sformatf("v%0d_dout_t2", i), ifa.dout, tbl[i].exp[0]);
        repeat (4) @(negedge g_clk);
        chk($sformatf("v%0d_level_peak", i), ifa.level, 5);
        chk($sformatf("v%0d_ready", i), ifa.ready, 0);
        for (int k = 0; k < 5; k++) begin
          pop_a(w);
          chk($sformatf("v%0d_word%0d", i, k), w, tbl[i].exp[k]);
        end
        chk($sformatf("v%0d_empty_after", i), ifa.empty, 1);
        chk($sformatf("v%0d_level_after", i), ifa.level, 0);
      end else begin
        repeat (7) @(negedge g_clk);
        chk($sformatf("v%0d_disabled_level", i), ifa.level, 0);
        chk($sformatf("v%0d_disabled_drop", i), ifa.drop_total, 0);
      end
    end
    ifa.enable = 1'b1;

    // Drop while a frame is in progress.
    reset_dut();
    pulse_a(pack4(32'd1, 32'd2, 32'd3, 32'd4));
    @(negedge g_clk);
    pulse_a(pack4(32'hBAD, 32'hBAD, 32'hBAD, 32'hBAD));
    chk("drop_total_1", ifa.drop_total, 1);
    pop_a(w); chk("drop_f1_hdr", w, 32'hA5000002);
    for (int k = 1; k <= 4; k++) begin pop_a(w); chk("drop_f1_data", w, 32'(k)); end
    pulse_a(pack4(32'd5, 32'd6, 32'd7, 32'd8));
    ifa.enable = 1'b0;   // deassert mid-frame; frame must still complete
    pop_a(w); chk("drop_f2_hdr", w, 32'hA5018102);
    for (int k = 5; k <= 8; k++) begin pop_a(w); chk("drop_f2_data", w, 32'(k)); end
    ifa.enable = 1'b1;
    // Drop in the header cycle counts toward the following header.
    pulse_a(pack4(32'd9, 32'd10, 32'd11, 32'd12));
    pulse_a(pack4(32'hBAD, 32'hBAD, 32'hBAD, 32'hBAD));
    pop_a(w); chk("drop_f3_hdr", w, 32'hA5020002);
    for (int k = 9; k <= 12; k++) begin pop_a(w); chk("drop_f3_data", w, 32'(k)); end
    chk("drop_total_2", ifa.drop_total, 2);
    pulse_a(pack4(32'd13, 32'd14, 32'd15, 32'd16));
    pop_a(w); chk("drop_f4_hdr", w, 32'hA5038102);
    for (int k = 13; k <= 16; k++) begin pop_a(w); chk("drop_f4_data", w, 32'(k)); end

    // Underflow: read while empty leaves dout on the last word.
    chk("uf_before", ifa.underflow, 0);
    ifa.rd_en = 1'b1;
    repeat (2) @(negedge g_clk);
    ifa.rd_en = 1'b0;
    chk("uf_set", ifa.underflow, 1);
    chk("uf_dout_hold", ifa.dout, 32'd16);
    chk("uf_level", ifa.level, 0);
    chk("uf_empty", ifa.empty, 1);

    // Asynchronous reset in the middle of the data words.
    pulse_a(pack4(32'd21, 32'd22, 32'd23, 32'd24));
    repeat (2) @(negedge g_clk);
    #2 c_rst = 1'b1;
    #1;
    chk("arst_dout", ifa.dout, 0);
    chk("arst_empty", ifa.empty, 1);
    chk("arst_ready", ifa.ready, 0);
    chk("arst_level", ifa.level, 0);
    chk("arst_drop", ifa.drop_total, 0);
    chk("arst_underflow", ifa.underflow, 0);
    @(negedge g_clk);
    c_rst = 1'b0;
    @(negedge g_clk);
    pulse_a(pack4(32'd31, 32'd32, 32'd33, 32'd34));
    pop_a(w); chk("arst_next_hdr", w, 32'hA5000002);
    for (int k = 31; k <= 34; k++) begin pop_a(w); chk("arst_next_data", w, 32'(k)); end

    // Sequence wrap with continuous draining.
    reset_dut();
    for (int i = 0; i < 300; i++) begin
      pulse_a(pack4(32'(i), 32'(i + 1), 32'(i + 2), 32'(i + 3)));
      pop_a(w);
      if (i == 256) chk("seq_wrap_256", w[23:16], 8'h00);
      chk($sformatf("seq_hdr%0d", i), w, {8'hA5, 8'(i), 16'h0002});
      for (int k = 0; k < 4; k++) begin
        pop_a(w);
        chk($sformatf("seq_data%0d_%0d", i, k), w, 32'(i + k));
      end
    end
    chk("seq_drops", ifa.drop_total, 0);

    // ready threshold at 16 words.
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      pulse_a(pack4(32'd1, 32'd2, 32'd3, 32'd4));
      repeat (6) @(negedge g_clk);
      if (i == 2) begin
        chk("rdy_level15", ifa.level, 15);
        chk("rdy_at15", ifa.ready, 0);
      end
    end
    chk("rdy_level20", ifa.level, 20);
    chk("rdy_at20", ifa.ready, 1);
    for (int k = 0; k < 4; k++) pop_a(w);
    chk("rdy_level16", ifa.level, 16);
    chk("rdy_at16", ifa.ready, 1);
    pop_a(w);
    chk("rdy_level15b", ifa.level, 15);
    chk("rdy_at15b", ifa.ready, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
